// File: rtl/misr_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : misr_check_sequencer
//  Purpose  : Autonomous MISR self-check engine. On start it streams a
//             Galois-LFSR word sequence into one MISR register over a
//             req/gnt/rvalid bus, reads the signature back and compares it
//             against a latched golden value.
//  Ports    : clk_i, rst_i (sync, active-high)
//             start_i, misr_sel_i, num_words_i, pattern_seed_i, golden_i
//                - run parameters, latched on an accepted start
//             req_o, we_o, be_o, addr_o, wdata_o  - bus request side
//             gnt_i, rvalid_i, rdata_i            - bus response side
//             busy_o, done_o, pass_o, timeout_o, signature_o - status
//  Revision : 1.0  initial release
// ============================================================================
module misr_check_sequencer #(
   parameter int              NBIT_MISR_DATA         = 32,
   parameter int              NBIT_AXI_WIDTH         = 64,
   parameter longint unsigned MISR_PERIPH_START_ADDR = 64'h0000_0000_0200_0000,
   parameter int              NBIT_CNT               = 16,
   parameter int              TIMEOUT_CYCLES         = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic                        misr_sel_i,
   input  logic [NBIT_CNT-1:0]         num_words_i,
   input  logic [31:0]                 pattern_seed_i,
   input  logic [NBIT_MISR_DATA-1:0]   golden_i,
   output logic                        req_o,
   output logic                        we_o,
   output logic [NBIT_AXI_WIDTH/8-1:0] be_o,
   output logic [NBIT_AXI_WIDTH-1:0]   addr_o,
   output logic [NBIT_AXI_WIDTH-1:0]   wdata_o,
   input  logic                        gnt_i,
   input  logic                        rvalid_i,
   input  logic [NBIT_AXI_WIDTH-1:0]   rdata_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        pass_o,
   output logic                        timeout_o,
   output logic [NBIT_MISR_DATA-1:0]   signature_o
);

   localparam int c_nbit_be  = NBIT_AXI_WIDTH / 8;
   localparam int c_nbit_tmo = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [NBIT_AXI_WIDTH-1:0] c_addr_reg1 = NBIT_AXI_WIDTH'(MISR_PERIPH_START_ADDR);
   localparam logic [NBIT_AXI_WIDTH-1:0] c_addr_reg2 = c_addr_reg1 + NBIT_AXI_WIDTH'(16);
   localparam logic [c_nbit_be-1:0]      c_be_word   = c_nbit_be'(4'hF);
   localparam logic [31:0]               c_lfsr_poly = 32'h8020_0003;
   localparam logic [c_nbit_tmo-1:0]     c_tmo_last  = c_nbit_tmo'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WRITE     = 3'd1,
      S_READ_REQ  = 3'd2,
      S_READ_WAIT = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      r_sel;
   logic [NBIT_CNT-1:0]       r_num;
   logic [NBIT_CNT-1:0]       r_cnt;
   logic [31:0]               r_lfsr;
   logic [NBIT_MISR_DATA-1:0] r_golden;
   logic [NBIT_MISR_DATA-1:0] r_sig;
   logic                      r_pass;
   logic                      r_timeout;
   logic [c_nbit_tmo-1:0]     r_tmo;

   logic [31:0]               w_lfsr_nxt;
   logic [NBIT_AXI_WIDTH-1:0] w_addr;
   logic                      w_last_word;
   logic                      w_waiting;
   logic                      w_progress;
   logic                      w_abort;
   logic [NBIT_MISR_DATA-1:0] w_rsig;
   logic                      w_unused_rdata;

   assign w_lfsr_nxt     = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_lfsr_poly : 32'h0);
   assign w_addr         = r_sel ? c_addr_reg2 : c_addr_reg1;
   // Only entered with r_num != 0, so r_num-1 never underflows here and the
   // counter never needs to reach 2^NBIT_CNT.
   assign w_last_word    = (r_cnt == r_num - NBIT_CNT'(1));
   assign w_rsig         = rdata_i[NBIT_MISR_DATA-1:0];
   assign w_unused_rdata = ^rdata_i[NBIT_AXI_WIDTH-1:NBIT_MISR_DATA];

   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign pass_o      = r_pass;
   assign timeout_o   = r_timeout;
   assign signature_o = r_sig;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_o       = 1'b0;
      we_o        = 1'b0;
      be_o        = '0;
      addr_o      = '0;
      wdata_o     = '0;
      w_progress  = 1'b0;
      w_waiting   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = (num_words_i != '0) ? S_WRITE : S_READ_REQ;
            end
         end
         S_WRITE: begin
            w_waiting = 1'b1;
            req_o     = 1'b1;
            we_o      = 1'b1;
            be_o      = c_be_word;
            addr_o    = w_addr;
            wdata_o   = NBIT_AXI_WIDTH'(r_lfsr);
            if (gnt_i) begin
               w_progress = 1'b1;
               if (w_last_word) begin
                  w_state_nxt = S_READ_REQ;
               end
            end
         end
         S_READ_REQ: begin
            w_waiting = 1'b1;
            req_o     = 1'b1;
            be_o      = c_be_word;
            addr_o    = w_addr;
            if (gnt_i) begin
               w_progress  = 1'b1;
               w_state_nxt = S_READ_WAIT;
            end
         end
         S_READ_WAIT: begin
            w_waiting = 1'b1;
            if (rvalid_i) begin
               w_progress  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // A grant/rvalid in the final allowed cycle still wins over the abort.
      w_abort = w_waiting && !w_progress && (r_tmo == c_tmo_last);
      if (w_abort) begin
         w_state_nxt = S_DONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sel     <= 1'b0;
         r_num     <= '0;
         r_cnt     <= '0;
         r_lfsr    <= '0;
         r_golden  <= '0;
         r_sig     <= '0;
         r_pass    <= 1'b0;
         r_timeout <= 1'b0;
         r_tmo     <= '0;
      end else begin
         if ((r_state == S_IDLE) && start_i) begin
            r_sel     <= misr_sel_i;
            r_num     <= num_words_i;
            r_cnt     <= '0;
            r_lfsr    <= (pattern_seed_i == 32'h0) ? 32'h1 : pattern_seed_i;
            r_golden  <= golden_i;
            r_sig     <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_tmo     <= '0;
         end
         // Progress of any kind (and every state change) restarts the wait.
         if (w_waiting) begin
            if (w_progress || w_abort) begin
               r_tmo <= '0;
            end else begin
               r_tmo <= r_tmo + c_nbit_tmo'(1);
            end
         end
         if ((r_state == S_WRITE) && gnt_i) begin
            r_lfsr <= w_lfsr_nxt;
            r_cnt  <= r_cnt + NBIT_CNT'(1);
         end
         if ((r_state == S_READ_WAIT) && rvalid_i) begin
            r_sig  <= w_rsig;
            r_pass <= (w_rsig == r_golden);
         end
         if (w_abort) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_misr_check_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_misr_check_sequencer
//  Purpose  : Self-checking bench for misr_check_sequencer. A transaction-
//             level model (queue of pending write words plus read/response
//             flags) predicts every output each cycle; directed runs pin
//             literal bus traffic, random runs exercise backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module tb_misr_check_sequencer;

   localparam int          TMO  = 64;
   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, misr_sel_i;
   logic [15:0] num_words_i;
   logic [31:0] pattern_seed_i, golden_i;
   logic        req_o, we_o;
   logic [7:0]  be_o;
   logic [63:0] addr_o, wdata_o;
   logic        gnt_i, rvalid_i;
   logic [63:0] rdata_i;
   logic        busy_o, done_o, pass_o, timeout_o;
   logic [31:0] signature_o;

   misr_check_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .misr_sel_i(misr_sel_i),
      .num_words_i(num_words_i), .pattern_seed_i(pattern_seed_i), .golden_i(golden_i),
      .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
      .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
      .signature_o(signature_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] m_q[$];
   bit          m_valid = 0, m_busy = 0, m_done = 0, m_rdreq = 0, m_rdwait = 0;
   bit          m_pass = 0, m_to = 0, m_sel = 0, m_prog;
   logic [31:0] m_sig = '0, m_golden = '0, m_v;
   int          m_wait = 0;

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_q.delete();
         m_valid = 1; m_busy = 0; m_done = 0; m_rdreq = 0; m_rdwait = 0;
         m_pass = 0; m_to = 0; m_sel = 0; m_sig = '0; m_golden = '0; m_wait = 0;
      end else if (m_done) begin
         m_done = 0;
         m_busy = 0;
      end else if (!m_busy) begin
         if (start_i) begin
            m_v = (pattern_seed_i == 0) ? 32'h1 : pattern_seed_i;
            m_q.delete();
            for (int i = 0; i < int'(num_words_i); i++) begin
               m_q.push_back(m_v);
               m_v = lfsr_next(m_v);
            end
            m_sel = misr_sel_i; m_golden = golden_i; m_busy = 1;
            m_pass = 0; m_to = 0; m_sig = '0; m_wait = 0;
            m_rdreq = (num_words_i == 0); m_rdwait = 0;
         end
      end else begin
         m_prog = 0;
         if (m_q.size() > 0) begin
            if (gnt_i) begin
               void'(m_q.pop_front());
               m_prog = 1;
               if (m_q.size() == 0) m_rdreq = 1;
            end
         end else if (m_rdreq) begin
            if (gnt_i) begin m_rdreq = 0; m_rdwait = 1; m_prog = 1; end
         end else if (m_rdwait) begin
            if (rvalid_i) begin
               m_sig = rdata_i[31:0]; m_pass = (m_sig == m_golden);
               m_rdwait = 0; m_done = 1; m_prog = 1;
            end
         end
         if (m_prog) m_wait = 0;
         else begin
            m_wait++;
            if (m_wait >= TMO) begin
               m_q.delete(); m_rdreq = 0; m_rdwait = 0;
               m_to = 1; m_pass = 0; m_done = 1; m_wait = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic e_req, e_wr;
   always @(negedge clk_i) begin
      if (m_valid) begin
         e_req = m_busy && !m_done && ((m_q.size() > 0) || m_rdreq);
         e_wr  = e_req && (m_q.size() > 0);
         check("req_o", req_o, e_req);
         check("we_o", we_o, e_wr);
         check("be_o", be_o, e_req ? 8'h0F : 8'h00);
         check("addr_o", addr_o, e_req ? (BASE + (m_sel ? 64'd16 : 64'd0)) : 64'd0);
         check("wdata_o", wdata_o, e_wr ? {32'h0, m_q[0]} : 64'd0);
         check("busy_o", busy_o, m_busy);
         check("done_o", done_o, m_done);
         check("pass_o", pass_o, m_pass);
         check("timeout_o", timeout_o, m_to);
         check("signature_o", signature_o, m_sig);
      end
   end

   // ---------------- bus responder / monitor ----------------
   int          gmode = 0, rdelay = 2, rv_cnt = -1, low_cnt = 0, wr_gnts = 0;
   bit          rmatch = 1;
   logic [31:0] golden_cur = '0;
   logic [63:0] wlog_addr[$], wlog_data[$], rlog_addr[$];
   int          req_total = 0, done_total = 0;

   always @(negedge clk_i) begin
      rvalid_i = 1'b0;
      rdata_i  = {$urandom(), $urandom()};
      if (rv_cnt > 0) begin
         rv_cnt--;
         if (rv_cnt == 0) begin
            rvalid_i = 1'b1;
            rdata_i  = {$urandom(), rmatch ? golden_cur : (golden_cur ^ 32'h1)};
            rv_cnt   = -1;
         end
      end
      case (gmode)
         0: gnt_i = 1'b1;
         1: gnt_i = ($urandom_range(0, 9) < 6);
         2: gnt_i = 1'b0;
         default: begin
            if (req_o && we_o && wr_gnts == 1 && low_cnt < 5) begin
               gnt_i = 1'b0;
               low_cnt++;
            end else gnt_i = 1'b1;
         end
      endcase
      if (req_o && gnt_i) begin
         if (we_o) begin
            wlog_addr.push_back(addr_o);
            wlog_data.push_back(wdata_o);
            wr_gnts++;
         end else begin
            rlog_addr.push_back(addr_o);
            if (rdelay > 0) rv_cnt = rdelay;
         end
      end
      if (req_o) req_total++;
      if (done_o) done_total++;
   end

   // ---------------- stimulus ----------------
   task automatic scramble();
      pattern_seed_i = $urandom();
      num_words_i    = 16'($urandom());
      golden_i       = $urandom();
      misr_sel_i     = 1'($urandom());
   endtask

   task automatic run(input logic [31:0] seed, input bit sel, input logic [15:0] num,
                      input logic [31:0] gold, input int gm, input int rd,
                      input bit rm, input bit poke);
      int budget;
      @(negedge clk_i);
      gmode = gm; rdelay = rd; rmatch = rm; golden_cur = gold; wr_gnts = 0; low_cnt = 0;
      pattern_seed_i = seed; misr_sel_i = sel; num_words_i = num; golden_i = gold;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      scramble();
      for (budget = (int'(num) + 3) * (TMO + 2); budget > 0 && !done_o; budget--) begin
         start_i = poke && ($urandom_range(0, 2) == 0);
         if (start_i) scramble();
         @(negedge clk_i);
      end
      check("done_within_budget", done_o, 1'b1);
      start_i = poke;
      if (poke) scramble();
      @(negedge clk_i);
      start_i = 1'b0;
      @(negedge clk_i);
   endtask

   int w0, r0, q0, d0;
   logic [31:0] exp_w;

   initial begin
      rst_i = 1'b1; start_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
      misr_sel_i = 1'b0; num_words_i = '0; pattern_seed_i = '0; golden_i = '0;
      repeat (3) @(negedge clk_i);
      check("reset_busy", busy_o, 1'b0);
      check("reset_addr", addr_o, 64'd0);
      rst_i = 1'b0;

      // Three words, grant tied high, rvalid two cycles after read grant.
      w0 = wlog_data.size(); r0 = rlog_addr.size(); q0 = req_total;
      run(32'h1, 1'b0, 16'd3, 32'hDEAD_BEEF, 0, 2, 1, 0);
      check("t1_nwrites", wlog_data.size() - w0, 3);
      check("t1_w0", wlog_data[w0], 64'h0000_0000_0000_0001);
      check("t1_w1", wlog_data[w0 + 1], 64'h0000_0000_8020_0003);
      check("t1_w2", wlog_data[w0 + 2], 64'h0000_0000_C030_0002);
      check("t1_waddr", wlog_addr[w0 + 2], 64'h0000_0000_0200_0000);
      check("t1_raddr", rlog_addr[r0], 64'h0000_0000_0200_0000);
      check("t1_req_cycles", req_total - q0, 4);
      check("t1_pass", pass_o, 1'b1);
      check("t1_sig", signature_o, 32'hDEAD_BEEF);

      // No writes, register 2, mismatching signature.
      w0 = wlog_data.size(); r0 = rlog_addr.size();
      run(32'h55, 1'b1, 16'd0, 32'h1234_5678, 0, 2, 0, 0);
      check("t2_nwrites", wlog_data.size() - w0, 0);
      check("t2_raddr", rlog_addr[r0], 64'h0000_0000_0200_0010);
      check("t2_pass", pass_o, 1'b0);
      check("t2_sig", signature_o, 32'h1234_5679);

      // Second write back-pressured for five cycles.
      w0 = wlog_data.size(); q0 = req_total;
      run(32'hACE1_2345, 1'b0, 16'd4, 32'h0BAD_F00D, 3, 1, 1, 0);
      check("t3_nwrites", wlog_data.size() - w0, 4);
      exp_w = 32'hACE1_2345;
      for (int i = 0; i < 4; i++) begin
         check("t3_word", wlog_data[w0 + i], {32'h0, exp_w});
         exp_w = lfsr_next(exp_w);
      end
      check("t3_req_cycles", req_total - q0, 10);

      // Grant never arrives: write timeout.
      w0 = wlog_data.size(); q0 = req_total; d0 = done_total;
      run(32'h9, 1'b0, 16'd5, 32'h0, 2, 2, 1, 0);
      check("t4_req_cycles", req_total - q0, TMO);
      check("t4_timeout", timeout_o, 1'b1);
      check("t4_pass", pass_o, 1'b0);
      check("t4_done_pulses", done_total - d0, 1);
      check("t4_nwrites", wlog_data.size() - w0, 0);

      // Read data never arrives: read timeout.
      run(32'h77, 1'b1, 16'd2, 32'h77, 0, -1, 1, 0);
      check("t4b_timeout", timeout_o, 1'b1);

      // Reset in the middle of a write burst, then a zero-seed run.
      @(negedge clk_i);
      gmode = 0; rdelay = 2;
      pattern_seed_i = 32'h1234; num_words_i = 16'd10; misr_sel_i = 1'b1; golden_i = 32'h0;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      d0 = done_total;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("t5_req_after_rst", req_o, 1'b0);
      check("t5_busy_after_rst", busy_o, 1'b0);
      check("t5_wdata_after_rst", wdata_o, 64'd0);
      repeat (5) @(negedge clk_i);
      check("t5_no_done", done_total - d0, 0);
      w0 = wlog_data.size();
      run(32'h0, 1'b0, 16'd2, 32'hCAFE_0001, 0, 3, 1, 0);
      check("t5_first_word", wlog_data[w0], 64'h0000_0000_0000_0001);
      check("t5_second_word", wlog_data[w0 + 1], 64'h0000_0000_8020_0003);

      // Start pulses while busy and during DONE must be ignored.
      w0 = wlog_data.size();
      run(32'h0F0F_3C3C, 1'b1, 16'd6, 32'h600D_600D, 1, 2, 1, 1);
      check("t6_nwrites", wlog_data.size() - w0, 6);
      check("t6_waddr", wlog_addr[w0], 64'h0000_0000_0200_0010);
      check("t6_pass", pass_o, 1'b1);

      // Randomized runs, checked against the model every cycle.
      for (int k = 0; k < 25; k++) begin
         run($urandom(), 1'($urandom()), 16'($urandom_range(0, 12)), $urandom(),
             1, int'($urandom_range(1, 4)), 1'($urandom()), 1'($urandom()));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
